// File: rtl/stack_pkg.sv
// Shared constants for the stack engine: FSM state encoding and default geometry.
// The peek extension is enabled by defining STACK_CONTROLLER_PEEK_EN.
package stack_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    READ    = 2'd2,
    CAPTURE = 2'd3
  } state_e;

  localparam int             DEFAULT_ADDR_WIDTH  = 10;
  localparam int             DEFAULT_DATA_WIDTH  = 8;
  localparam logic [9:0]     DEFAULT_STACK_BASE  = 10'h3FF;
  localparam int             DEFAULT_STACK_DEPTH = 64;

endpackage

// File: rtl/stack_controller_if.sv
// CPU request/response and data_memory port bundle for stack_controller.
// The in_peek request exists only when STACK_CONTROLLER_PEEK_EN is defined.
interface stack_controller_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
);

  logic                  in_push;
  logic                  in_pop;
  logic [DATA_WIDTH-1:0] in_data;
`ifdef STACK_CONTROLLER_PEEK_EN
  logic                  in_peek;
`endif
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_busy;
  logic                  out_full;
  logic                  out_empty;
  logic                  out_err;
  logic [ADDR_WIDTH-1:0] out_mem_addr;
  logic                  out_mem_write_en;
  logic [DATA_WIDTH-1:0] out_mem_data;
  logic [DATA_WIDTH-1:0] in_mem_data;

`ifdef STACK_CONTROLLER_PEEK_EN
  modport slave (
    input  in_push, in_pop, in_data, in_peek, in_mem_data,
    output out_data, out_valid, out_busy, out_full, out_empty, out_err,
           out_mem_addr, out_mem_write_en, out_mem_data
  );
  modport master (
    output in_push, in_pop, in_data, in_peek, in_mem_data,
    input  out_data, out_valid, out_busy, out_full, out_empty, out_err,
           out_mem_addr, out_mem_write_en, out_mem_data
  );
`else
  modport slave (
    input  in_push, in_pop, in_data, in_mem_data,
    output out_data, out_valid, out_busy, out_full, out_empty, out_err,
           out_mem_addr, out_mem_write_en, out_mem_data
  );
  modport master (
    output in_push, in_pop, in_data, in_mem_data,
    input  out_data, out_valid, out_busy, out_full, out_empty, out_err,
           out_mem_addr, out_mem_write_en, out_mem_data
  );
`endif

endinterface

// File: rtl/stack_pointer.sv
// Occupancy counter for a downward-growing stack; derives full/empty flags
// and the top-of-stack and next-free addresses from the registered count.
module stack_pointer
  import stack_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] STACK_BASE  = ADDR_WIDTH'(DEFAULT_STACK_BASE),
  parameter int                    STACK_DEPTH = DEFAULT_STACK_DEPTH,
  parameter int                    CNT_WIDTH   = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc_i,
  input  logic                  dec_i,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH-1:0] topAddr_o,
  output logic [ADDR_WIDTH-1:0] freeAddr_o
);

  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(STACK_DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE_CNT   = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;
  logic                 canInc;
  logic                 canDec;

  // Saturating guards keep the count in range even if a caller misbehaves.
  always_comb begin
    canInc  = inc_i && (count_q != DEPTH_CNT);
    canDec  = dec_i && (count_q != '0);
    count_d = count_q;
    if (canInc && !canDec) begin
      count_d = count_q + ONE_CNT;
    end else if (canDec && !canInc) begin
      count_d = count_q - ONE_CNT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    count_o    = count_q;
    full_o     = (count_q == DEPTH_CNT);
    empty_o    = (count_q == '0);
    freeAddr_o = STACK_BASE - ADDR_WIDTH'(count_q);
    topAddr_o  = STACK_BASE - ADDR_WIDTH'(count_q) + ADDR_WIDTH'(1);
  end

endmodule

// File: rtl/stack_controller.sv
// Stack engine driving a write-first, registered-read data memory; push/pop/peek
// sequencing FSM. Peek support is compiled in with STACK_CONTROLLER_PEEK_EN.
module stack_controller
  import stack_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] STACK_BASE  = ADDR_WIDTH'(DEFAULT_STACK_BASE),
  parameter int                    STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
  input logic               clk,
  input logic               rst,
  stack_controller_if.slave bus
);

  localparam int CNT_WIDTH = $clog2(STACK_DEPTH + 1);

  state_e                state_q;
  state_e                state_d;
  logic [DATA_WIDTH-1:0] wrData_q;
  logic [DATA_WIDTH-1:0] wrData_d;
  logic [ADDR_WIDTH-1:0] memAddr_q;
  logic [ADDR_WIDTH-1:0] memAddr_d;
  logic                  memWe_q;
  logic                  memWe_d;
  logic [DATA_WIDTH-1:0] outData_q;
  logic [DATA_WIDTH-1:0] outData_d;
  logic                  outValid_q;
  logic                  outValid_d;
  logic                  err_q;
  logic                  err_d;
  logic                  peekOp_q;
  logic                  peekOp_d;

  logic                  spInc;
  logic                  spDec;
  logic [CNT_WIDTH-1:0]  count;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH-1:0] topAddr;
  logic [ADDR_WIDTH-1:0] freeAddr;
  logic                  collision;
  logic                  readReq;

  stack_pointer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STACK_BASE (STACK_BASE),
    .STACK_DEPTH(STACK_DEPTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_stack_pointer (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (spInc),
    .dec_i     (spDec),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty),
    .topAddr_o (topAddr),
    .freeAddr_o(freeAddr)
  );

  // More than one simultaneous request is a collision; a read request is a
  // pop or (when enabled) a peek arriving on its own.
`ifdef STACK_CONTROLLER_PEEK_EN
  always_comb begin
    collision = (bus.in_push && bus.in_pop) || (bus.in_push && bus.in_peek) ||
                (bus.in_pop && bus.in_peek);
    readReq   = bus.in_pop || bus.in_peek;
  end
`else
  always_comb begin
    collision = bus.in_push && bus.in_pop;
    readReq   = bus.in_pop;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wrData_q   <= '0;
      memAddr_q  <= STACK_BASE;
      memWe_q    <= 1'b0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      err_q      <= 1'b0;
      peekOp_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wrData_q   <= wrData_d;
      memAddr_q  <= memAddr_d;
      memWe_q    <= memWe_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      err_q      <= err_d;
      peekOp_q   <= peekOp_d;
    end
  end

  // Memory-port values are registered on entry to WRITE/READ so they are stable
  // for the whole access cycle and simply hold once the FSM is back in IDLE.
  always_comb begin
    state_d    = state_q;
    wrData_d   = wrData_q;
    memAddr_d  = memAddr_q;
    memWe_d    = 1'b0;
    outData_d  = outData_q;
    outValid_d = 1'b0;
    err_d      = err_q;
    peekOp_d   = peekOp_q;
    spInc      = 1'b0;
    spDec      = 1'b0;
    case (state_q)
      IDLE: begin
        if (collision) begin
          err_d = 1'b1;
        end else if (bus.in_push) begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            wrData_d  = bus.in_data;
            memAddr_d = freeAddr;
            memWe_d   = 1'b1;
            state_d   = WRITE;
          end
        end else if (readReq) begin
          if (empty) begin
            err_d = 1'b1;
          end else begin
            memAddr_d = topAddr;
            peekOp_d  = !bus.in_pop;
            state_d   = READ;
          end
        end
      end
      WRITE: begin
        spInc   = 1'b1;
        state_d = IDLE;
      end
      READ: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        outData_d  = bus.in_mem_data;
        outValid_d = 1'b1;
        spDec      = !peekOp_q && (count != '0);
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.out_data         = outData_q;
    bus.out_valid        = outValid_q;
    bus.out_busy         = (state_q != IDLE);
    bus.out_full         = full;
    bus.out_empty        = empty;
    bus.out_err          = err_q;
    bus.out_mem_addr     = memAddr_q;
    bus.out_mem_write_en = memWe_q;
    bus.out_mem_data     = wrData_q;
  end

endmodule

// File: tb/tb_stack_controller.sv
// Self-checking bench for stack_controller: queue-based reference model plus
// directed push/pop/collision/reset scenarios against a write-first memory.
module tb_stack_controller;

  localparam int DEPTH = 64;
  localparam int BASE  = 1023;

  logic clk;
  logic rst;

  int nCompared;
  int nMismatched;

  stack_controller_if #(.ADDR_WIDTH(10), .DATA_WIDTH(8)) bus ();

  stack_controller #(
    .ADDR_WIDTH (10),
    .DATA_WIDTH (8),
    .STACK_BASE (10'h3FF),
    .STACK_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory: write-first, registered read.
  logic [7:0] mem [0:1023];
  logic [7:0] rdMem;
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    rdMem = 8'h00;
  end
  always @(posedge clk) begin
    if (bus.out_mem_write_en) mem[bus.out_mem_addr] <= bus.out_mem_data;
    rdMem <= bus.out_mem_write_en ? bus.out_mem_data : mem[bus.out_mem_addr];
  end
  assign bus.in_mem_data = rdMem;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stack is a queue; an accepted push completes one edge
  // later, an accepted pop or read completes two edges later.
  logic [7:0] stackQ[$];
  int         busyLeft;
  bit         pendIsPush;
  logic [7:0] pendData;
  logic [7:0] expData;
  bit         expValid;
  bit         expErr;
  logic [9:0] expAddr;
  bit         modelReady;

  initial modelReady = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      stackQ.delete();
      busyLeft   = 0;
      pendIsPush = 1'b0;
      pendData   = 8'h00;
      expData    = 8'h00;
      expValid   = 1'b0;
      expErr     = 1'b0;
      expAddr    = 10'h3FF;
      modelReady = 1'b1;
    end else if (modelReady) begin
      expValid = 1'b0;
      if (busyLeft > 0) begin
        busyLeft--;
        if (busyLeft == 0) begin
          if (pendIsPush) begin
            stackQ.push_back(pendData);
          end else begin
            expData  = stackQ.pop_back();
            expValid = 1'b1;
          end
        end
      end else if (bus.in_push && bus.in_pop) begin
        expErr = 1'b1;
      end else if (bus.in_push) begin
        if (stackQ.size() == DEPTH) begin
          expErr = 1'b1;
        end else begin
          pendIsPush = 1'b1;
          pendData   = bus.in_data;
          expAddr    = 10'(BASE - stackQ.size());
          busyLeft   = 1;
        end
      end else if (bus.in_pop) begin
        if (stackQ.size() == 0) begin
          expErr = 1'b1;
        end else begin
          pendIsPush = 1'b0;
          expAddr    = 10'(BASE + 1 - stackQ.size());
          busyLeft   = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("cmp busy",  32'(bus.out_busy),         32'(busyLeft > 0));
      checkOutput("cmp empty", 32'(bus.out_empty),        32'(stackQ.size() == 0));
      checkOutput("cmp full",  32'(bus.out_full),         32'(stackQ.size() == DEPTH));
      checkOutput("cmp err",   32'(bus.out_err),          32'(expErr));
      checkOutput("cmp valid", 32'(bus.out_valid),        32'(expValid));
      checkOutput("cmp data",  32'(bus.out_data),         32'(expData));
      checkOutput("cmp we",    32'(bus.out_mem_write_en), 32'(busyLeft > 0 && pendIsPush));
      checkOutput("cmp addr",  32'(bus.out_mem_addr),     32'(expAddr));
      if (busyLeft > 0 && pendIsPush)
        checkOutput("cmp wdata", 32'(bus.out_mem_data), 32'(pendData));
    end
  end

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitIdle();
    int k;
    k = 0;
    while (bus.out_busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (bus.out_busy) checkOutput("waitIdle timeout", 32'(1), 32'(0));
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic [9:0] addrExp);
    @(negedge clk);
    bus.in_push = 1'b1;
    bus.in_data = d;
    @(negedge clk);
    bus.in_push = 1'b0;
    checkOutput("push we",    32'(bus.out_mem_write_en), 32'(1));
    checkOutput("push addr",  32'(bus.out_mem_addr),     32'(addrExp));
    checkOutput("push wdata", 32'(bus.out_mem_data),     32'(d));
    waitIdle();
  endtask

  task automatic popExpect(input logic [7:0] d);
    bit got;
    int lat;
    got = 1'b0;
    lat = 0;
    @(negedge clk);
    bus.in_pop = 1'b1;
    @(negedge clk);
    bus.in_pop = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got = 1'b1;
        lat = k + 2;
      end
    end
    checkOutput("pop valid seen", 32'(got), 32'(1));
    checkOutput("pop latency",    32'(lat), 32'(3));
    checkOutput("pop data",       32'(bus.out_data), 32'(d));
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst         = 1'b1;
    bus.in_push = 1'b0;
    bus.in_pop  = 1'b0;
    bus.in_data = 8'h00;
`ifdef STACK_CONTROLLER_PEEK_EN
    bus.in_peek = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst empty", 32'(bus.out_empty),        32'(1));
    checkOutput("rst we",    32'(bus.out_mem_write_en), 32'(0));
    checkOutput("rst addr",  32'(bus.out_mem_addr),     32'h3FF);
    checkOutput("rst err",   32'(bus.out_err),          32'(0));
    checkOutput("rst full",  32'(bus.out_full),         32'(0));

    $display("[TB] single push/pop");
    applyStimulus(8'h55, 10'h3FF);
    checkOutput("one entry empty", 32'(bus.out_empty), 32'(0));
    popExpect(8'h55);
    checkOutput("after pop empty", 32'(bus.out_empty), 32'(1));

    $display("[TB] LIFO ordering");
    applyStimulus(8'h02, 10'h3FF);
    applyStimulus(8'h04, 10'h3FE);
    applyStimulus(8'h08, 10'h3FD);
    popExpect(8'h08);
    popExpect(8'h04);
    popExpect(8'h02);
    checkOutput("lifo empty", 32'(bus.out_empty), 32'(1));

    $display("[TB] fill to depth");
    for (int i = 0; i < DEPTH; i++) applyStimulus(8'(i + 1), 10'(BASE - i));
    checkOutput("full flag", 32'(bus.out_full), 32'(1));
    @(negedge clk);
    bus.in_push = 1'b1;
    bus.in_data = 8'hEE;
    @(negedge clk);
    bus.in_push = 1'b0;
    checkOutput("overflow we",   32'(bus.out_mem_write_en), 32'(0));
    checkOutput("overflow err",  32'(bus.out_err),          32'(1));
    checkOutput("overflow busy", 32'(bus.out_busy),         32'(0));
    for (int i = DEPTH; i > 0; i--) popExpect(8'(i));
    checkOutput("drained empty", 32'(bus.out_empty), 32'(1));

    $display("[TB] underflow");
    applyReset();
    @(negedge clk);
    bus.in_pop = 1'b1;
    @(negedge clk);
    bus.in_pop = 1'b0;
    checkOutput("underflow err",  32'(bus.out_err),  32'(1));
    checkOutput("underflow busy", 32'(bus.out_busy), 32'(0));
    repeat (3) begin
      @(negedge clk);
      checkOutput("underflow no valid", 32'(bus.out_valid), 32'(0));
    end

    $display("[TB] push+pop collision");
    applyReset();
    @(negedge clk);
    bus.in_push = 1'b1;
    bus.in_pop  = 1'b1;
    bus.in_data = 8'h77;
    @(negedge clk);
    bus.in_push = 1'b0;
    bus.in_pop  = 1'b0;
    checkOutput("collide we",    32'(bus.out_mem_write_en), 32'(0));
    checkOutput("collide busy",  32'(bus.out_busy),         32'(0));
    checkOutput("collide err",   32'(bus.out_err),          32'(1));
    checkOutput("collide empty", 32'(bus.out_empty),        32'(1));

    $display("[TB] requests while busy are dropped");
    applyReset();
    @(negedge clk);
    bus.in_push = 1'b1;
    bus.in_data = 8'h11;
    @(negedge clk);
    bus.in_push = 1'b0;
    bus.in_pop  = 1'b1;
    @(negedge clk);
    bus.in_pop  = 1'b0;
    waitIdle();
    checkOutput("busy pop dropped", 32'(bus.out_empty), 32'(0));
    checkOutput("busy no err",      32'(bus.out_err),   32'(0));
    @(negedge clk);
    bus.in_pop = 1'b1;
    @(negedge clk);
    bus.in_pop  = 1'b0;
    bus.in_push = 1'b1;
    bus.in_data = 8'h22;
    @(negedge clk);
    bus.in_push = 1'b0;
    waitIdle();
    checkOutput("busy push dropped", 32'(bus.out_empty), 32'(1));
    checkOutput("busy pop data",     32'(bus.out_data),  32'h11);

    $display("[TB] reset during WRITE");
    applyStimulus(8'h33, 10'h3FF);
    @(negedge clk);
    bus.in_push = 1'b1;
    bus.in_data = 8'hAA;
    @(negedge clk);
    bus.in_push = 1'b0;
    checkOutput("in WRITE we", 32'(bus.out_mem_write_en), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst WRITE we",    32'(bus.out_mem_write_en), 32'(0));
    checkOutput("rst WRITE empty", 32'(bus.out_empty),        32'(1));
    checkOutput("rst WRITE busy",  32'(bus.out_busy),         32'(0));
    checkOutput("rst WRITE addr",  32'(bus.out_mem_addr),     32'h3FF);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, compared %0d", nCompared);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
